// File: rtl/ov7670_gen_pkg.sv
// rtl/ov7670_gen_pkg.sv - state encoding, colour-bar tables and chroma constant for the OV7670 emulator
package ov7670_gen_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_VSYNC  = 3'd1;
  localparam state_t ST_VBP    = 3'd2;
  localparam state_t ST_ACTIVE = 3'd3;
  localparam state_t ST_HBLANK = 3'd4;
  localparam state_t ST_VFP    = 3'd5;

  // Index 0 (rightmost) is white, index 7 (leftmost) is black.
  localparam logic [7:0][15:0] RGB565_TBL = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  localparam logic [7:0][7:0] Y_TBL = {
    8'h10, 8'h29, 8'h51, 8'h6A, 8'h91, 8'hAA, 8'hD2, 8'hEB
  };

  localparam logic [7:0] CHROMA = 8'h80;

endpackage

// File: rtl/ov7670_bar_lut.sv
// rtl/ov7670_bar_lut.sv - maps bar index, colour mode and byte phase to the output pixel byte
module ov7670_bar_lut
  import ov7670_gen_pkg::*;
(
  input  logic [2:0] bar,
  input  logic       rgbmode,
  input  logic       phase,
  output logic [7:0] d
);

  always_comb begin
    d = 8'h00;
    if (rgbmode) begin
      d = phase ? RGB565_TBL[bar][7:0] : RGB565_TBL[bar][15:8];
    end else begin
      d = phase ? Y_TBL[bar] : CHROMA;
    end
  end

endmodule

// File: rtl/ov7670_stream_gen.sv
// rtl/ov7670_stream_gen.sv - OV7670 parallel-video emulator: pclk divider, frame FSM, counters
// Optional OV7670_GEN_SCROLL_EN: bars scroll left one pixel per frame.
module ov7670_stream_gen
  import ov7670_gen_pkg::*;
#(
  parameter int H_ACT     = 160,
  parameter int V_ACT     = 120,
  parameter int H_BLANK   = 16,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 2,
  parameter int VFP_LINES = 2,
  parameter int PCLK_HALF = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       rgbmode,
  output logic       pclk,
  output logic       vsync,
  output logic       href,
  output logic [7:0] d,
  output logic       frame_start
);

  localparam int LINE_LEN = 2 * H_ACT + H_BLANK;
  localparam int BW = $clog2(LINE_LEN);
  localparam int LW = $clog2(VS_LINES + VBP_LINES + V_ACT + VFP_LINES + 1);
  localparam int PW = $clog2(2 * PCLK_HALF);
  localparam int unsigned H_ACT_U = H_ACT;

  localparam logic [PW-1:0] PH_LAST   = PW'(2 * PCLK_HALF - 1);
  localparam logic [PW-1:0] PH_RISE   = PW'(PCLK_HALF);
  localparam logic [BW-1:0] BYTE_LAST = BW'(LINE_LEN - 1);
  localparam logic [BW-1:0] ACT_LAST  = BW'(2 * H_ACT - 1);
  localparam logic [LW-1:0] VS_LAST   = LW'(VS_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST  = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] VACT_LAST = LW'(V_ACT - 1);
  localparam logic [LW-1:0] VFP_LAST  = LW'(VFP_LINES - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [LW-1:0] line_q, line_d;
  logic          mode_q, mode_d;
  logic          pclk_q, pclk_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    d_q, d_d;
  logic          frame_start_q, frame_start_d;
  logic          start, fall, line_end;
  logic [31:0]   scroll, col;
  logic [2:0]    bar;
  logic [7:0]    lut_byte;

  // Everything advances on the clk edge where pclk falls; the start edge counts as one.
  always_comb begin
    state_d       = state_q;
    ph_d          = ph_q;
    byte_d        = byte_q;
    line_d        = line_q;
    mode_d        = mode_q;
    frame_start_d = 1'b0;
    start         = 1'b0;
    fall          = (state_q != ST_IDLE) && (ph_q == PH_LAST);
    line_end      = (byte_q == BYTE_LAST);

    if (state_q == ST_IDLE) begin
      start = en;
    end else begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + PW'(1);
      if (fall) begin
        byte_d = line_end ? '0 : byte_q + BW'(1);
        case (state_q)
          ST_VSYNC: if (line_end) begin
            if (line_q == VS_LAST) begin
              state_d = ST_VBP;
              line_d  = '0;
            end else line_d = line_q + LW'(1);
          end
          ST_VBP: if (line_end) begin
            if (line_q == VBP_LAST) begin
              state_d = ST_ACTIVE;
              line_d  = '0;
            end else line_d = line_q + LW'(1);
          end
          ST_ACTIVE: if (byte_q == ACT_LAST) state_d = ST_HBLANK;
          ST_HBLANK: if (line_end) begin
            if (line_q == VACT_LAST) begin
              state_d = ST_VFP;
              line_d  = '0;
            end else begin
              state_d = ST_ACTIVE;
              line_d  = line_q + LW'(1);
            end
          end
          ST_VFP: if (line_end) begin
            if (line_q == VFP_LAST) begin
              line_d  = '0;
              state_d = ST_IDLE;
              start   = en;
            end else line_d = line_q + LW'(1);
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (start) begin
      state_d       = ST_VSYNC;
      ph_d          = '0;
      byte_d        = '0;
      line_d        = '0;
      mode_d        = rgbmode;
      frame_start_d = 1'b1;
    end
  end

`ifdef OV7670_GEN_SCROLL_EN
  localparam int CW = $clog2(H_ACT + 1);
  localparam logic [CW-1:0] FC_LAST = CW'(H_ACT - 1);

  logic [CW-1:0] fcnt_q, fcnt_d, off_q, off_d;

  // off_q holds the offset of the frame in progress; fcnt_q already points at the next one.
  always_comb begin
    fcnt_d = fcnt_q;
    off_d  = off_q;
    if (start) begin
      off_d  = fcnt_q;
      fcnt_d = (fcnt_q == FC_LAST) ? '0 : fcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fcnt_q <= '0;
      off_q  <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      off_q  <= off_d;
    end
  end

  assign scroll = 32'(off_d);
`else
  assign scroll = '0;
`endif

  always_comb begin
    col = 32'(byte_d >> 1) + scroll;
    if (col >= H_ACT_U) col = col - H_ACT_U;
    bar = 3'((col * 32'd8) / H_ACT_U);
  end

  ov7670_bar_lut u_lut (
    .bar     (bar),
    .rgbmode (mode_d),
    .phase   (byte_d[0]),
    .d       (lut_byte)
  );

  always_comb begin
    pclk_d  = (state_d != ST_IDLE) && (ph_d >= PH_RISE);
    vsync_d = (state_d == ST_VSYNC);
    href_d  = (state_d == ST_ACTIVE);
    d_d     = href_d ? lut_byte : 8'h00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      ph_q          <= '0;
      byte_q        <= '0;
      line_q        <= '0;
      mode_q        <= 1'b0;
      pclk_q        <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      d_q           <= 8'h00;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ph_q          <= ph_d;
      byte_q        <= byte_d;
      line_q        <= line_d;
      mode_q        <= mode_d;
      pclk_q        <= pclk_d;
      vsync_q       <= vsync_d;
      href_q        <= href_d;
      d_q           <= d_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pclk        = pclk_q;
  assign vsync       = vsync_q;
  assign href        = href_q;
  assign d           = d_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_ov7670_stream_gen.sv
// tb/tb_ov7670_stream_gen.sv - self-checking bench for ov7670_stream_gen with a byte scoreboard
module tb_ov7670_stream_gen;

  localparam int H_ACT     = 4;
  localparam int V_ACT     = 2;
  localparam int H_BLANK   = 4;
  localparam int VS_LINES  = 1;
  localparam int VBP_LINES = 1;
  localparam int VFP_LINES = 1;
  localparam int PCLK_HALF = 2;
  localparam int FRAME_CLKS = 2 * PCLK_HALF * (2 * H_ACT + H_BLANK) * (VS_LINES + VBP_LINES + V_ACT + VFP_LINES);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       rgbmode = 1'b0;
  logic       pclk, vsync, href, frame_start;
  logic [7:0] d;

  int total = 0;
  int bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  logic [15:0] rgb_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
  logic [7:0]  y_tab   [8] = '{8'hEB, 8'hD2, 8'hAA, 8'h91, 8'h6A, 8'h51, 8'h29, 8'h10};

  ov7670_stream_gen #(
    .H_ACT(H_ACT), .V_ACT(V_ACT), .H_BLANK(H_BLANK), .VS_LINES(VS_LINES),
    .VBP_LINES(VBP_LINES), .VFP_LINES(VFP_LINES), .PCLK_HALF(PCLK_HALF)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .rgbmode(rgbmode),
    .pclk(pclk), .vsync(vsync), .href(href), .d(d), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input logic mode, input int b, input int off);
    int c;
    int bar;
    c   = ((b / 2) + off) % H_ACT;
    bar = (c * 8) / H_ACT;
    if (mode) return (b % 2 == 0) ? rgb_tab[bar][15:8] : rgb_tab[bar][7:0];
    return (b % 2 == 0) ? 8'h80 : y_tab[bar];
  endfunction

  task automatic push_frame(input logic mode, input int fidx);
    int off;
`ifdef OV7670_GEN_SCROLL_EN
    off = fidx % H_ACT;
`else
    off = 0;
`endif
    for (int ln = 0; ln < V_ACT; ln++)
      for (int b = 0; b < 2 * H_ACT; b++)
        exp_q.push_back(exp_byte(mode, b, off));
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) check(tag, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_fs(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound && !ok; i++) begin
      tick();
      if (frame_start) ok = 1'b1;
    end
  endtask

  // Called just after the edge that raised frame_start; returns 0 cycles if no next frame starts.
  task automatic run_frame(input int toggle_at, input logic new_mode, input logic new_en,
                           output int cycles, output int vs_n, output int hr_n, output int blank_bad);
    logic prev;
    prev = pclk;
    cycles = 0; vs_n = 0; hr_n = 0; blank_bad = 0;
    for (int cyc = 1; cyc <= FRAME_CLKS + 60; cyc++) begin
      if (cyc == toggle_at) begin
        rgbmode = new_mode;
        en = new_en;
      end
      tick();
      if (!href && d !== 8'h00) blank_bad++;
      if (pclk && !prev) begin
        if (vsync) vs_n++;
        if (href) begin
          hr_n++;
          obs_q.push_back(d);
        end
      end
      prev = pclk;
      if (frame_start) begin
        cycles = cyc;
        break;
      end
    end
  endtask

  initial begin
    logic ok;
    int cyc, vs_n, hr_n, bb, rises;
    logic prev;

    rst = 1'b0; en = 1'b1; rgbmode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("reset_outputs", {pclk, vsync, href, frame_start, d}, 32'h0);
    end

    rst = 1'b1;
    wait_fs(2 * PCLK_HALF + 2, ok);
    check("start_seen", ok, 1);
    check("start_vsync", vsync, 1);
    check("start_href", href, 0);
    check("start_pclk", pclk, 0);

    push_frame(1'b1, 0);
    run_frame(FRAME_CLKS / 2, 1'b0, 1'b1, cyc, vs_n, hr_n, bb);
    check("f0_period", cyc, FRAME_CLKS);
    check("f0_vsync_pclks", vs_n, 12);
    check("f0_href_pclks", hr_n, 16);
    check("f0_blank_d", bb, 0);
    compare_bytes("f0_rgb_bytes");

    push_frame(1'b0, 1);
    run_frame(FRAME_CLKS / 2, 1'b1, 1'b1, cyc, vs_n, hr_n, bb);
    check("f1_period", cyc, FRAME_CLKS);
    check("f1_vsync_pclks", vs_n, 12);
    check("f1_href_pclks", hr_n, 16);
    check("f1_blank_d", bb, 0);
    compare_bytes("f1_yuv_bytes");

    push_frame(1'b1, 2);
    run_frame(FRAME_CLKS / 2, 1'b1, 1'b0, cyc, vs_n, hr_n, bb);
    check("f2_no_restart", cyc, 0);
    check("f2_vsync_pclks", vs_n, 12);
    check("f2_href_pclks", hr_n, 16);
    check("f2_blank_d", bb, 0);
    compare_bytes("f2_rgb_bytes");
    check("idle_outputs", {pclk, vsync, href, d}, 32'h0);

    rises = 0;
    prev = pclk;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pclk && !prev) rises++;
      prev = pclk;
    end
    check("idle_pclk_rises", rises, 0);

    en = 1'b1;
    wait_fs(2 * PCLK_HALF + 2, ok);
    check("restart_seen", ok, 1);
    ok = 1'b0;
    for (int i = 0; i < FRAME_CLKS && !ok; i++) begin
      tick();
      if (href) ok = 1'b1;
    end
    check("reach_active", ok, 1);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1 check("async_reset_now", {pclk, vsync, href, frame_start, d}, 32'h0);
    tick();
    check("async_reset_held", {pclk, vsync, href, frame_start, d}, 32'h0);

    rst = 1'b1;
    wait_fs(2 * PCLK_HALF + 2, ok);
    check("post_reset_start", ok, 1);
    check("post_reset_vsync", vsync, 1);
    check("post_reset_href", href, 0);
    push_frame(1'b1, 0);
    run_frame(0, 1'b1, 1'b1, cyc, vs_n, hr_n, bb);
    check("f3_period", cyc, FRAME_CLKS);
    check("f3_vsync_pclks", vs_n, 12);
    check("f3_href_pclks", hr_n, 16);
    check("f3_blank_d", bb, 0);
    compare_bytes("f3_rgb_bytes");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
